ctrl_responder: RTL and testbench

- Datapath-side responder for the VeriRISC controller.
- Consumes the controller's seven strobes (mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr) and returns opcode and zero to it.
- Contains the PC, IR, accumulator and a 32-word unified program/data memory.
- Closes the loop so the controller runs real programs instead of pattern files.

---
 rtl/ctrl_responder.sv | 140 ++++++++++++++
 tb/tb_ctrl_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_responder.sv
// rtl/ctrl_responder.sv - VeriRISC datapath responder: PC, IR, accumulator and 32-word unified memory
// Optional protocol checker on seq_err is built only when RESP_SEQ_CHECK_EN is defined.
module ctrl_responder #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5,
  parameter int OPW    = 3
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              mem_rd,
  input  logic              load_ir,
  input  logic              halt,
  input  logic              inc_pc,
  input  logic              load_ac,
  input  logic              load_pc,
  input  logic              mem_wr,
  output logic [OPW-1:0]    opcode,
  output logic              zero,
  input  logic              prog_we,
  input  logic [AWIDTH-1:0] prog_addr,
  input  logic [DWIDTH-1:0] prog_data,
  output logic [AWIDTH-1:0] pc_out,
  output logic [DWIDTH-1:0] ac_out,
  output logic              halted,
  output logic              seq_err
);

  localparam logic [OPW-1:0] OP_ADD = 3'd2;
  localparam logic [OPW-1:0] OP_AND = 3'd3;
  localparam logic [OPW-1:0] OP_XOR = 3'd4;
  localparam logic [OPW-1:0] OP_LDA = 3'd5;

  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [2:0]        phase;
  logic [AWIDTH-1:0] pc;
  logic [AWIDTH-1:0] addr;
  logic [AWIDTH-1:0] operand;
  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] ac;
  logic [DWIDTH-1:0] rdata;
  logic [DWIDTH-1:0] alu_res;
  logic              halted_q;
  logic              load_ir_q, inc_pc_q, load_ac_q, load_pc_q, mem_wr_q;
  logic              ir_go, inc_go, ac_go, pc_go, wr_go;

  assign operand = ir[AWIDTH-1:0];
  // Phases 4-7 address the operand, 0-3 the instruction stream.
  assign addr    = phase[2] ? operand : pc;
  assign rdata   = mem_rd ? mem[addr] : '0;
  assign opcode  = ir[DWIDTH-1 -: OPW];
  assign zero    = (ac == '0);
  assign pc_out  = pc;
  assign ac_out  = ac;
  assign halted  = halted_q;

  // A strobe acts only in the first cycle it is seen high.
  assign ir_go  = load_ir & ~load_ir_q;
  assign inc_go = inc_pc  & ~inc_pc_q;
  assign ac_go  = load_ac & ~load_ac_q;
  assign pc_go  = load_pc & ~load_pc_q;
  assign wr_go  = mem_wr  & ~mem_wr_q;

  always_comb begin
    alu_res = ac;
    case (opcode)
      OP_ADD:  alu_res = ac + rdata;
      OP_AND:  alu_res = ac & rdata;
      OP_XOR:  alu_res = ac ^ rdata;
      OP_LDA:  alu_res = rdata;
      default: alu_res = ac;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      pc        <= '0;
      ir        <= '0;
      ac        <= '0;
      phase     <= 3'd0;
      halted_q  <= 1'b0;
      load_ir_q <= 1'b0;
      inc_pc_q  <= 1'b0;
      load_ac_q <= 1'b0;
      load_pc_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      if (prog_we)
        mem[prog_addr] <= prog_data;
    end else if (!halted_q) begin
      phase     <= phase + 3'd1;
      load_ir_q <= load_ir;
      inc_pc_q  <= inc_pc;
      load_ac_q <= load_ac;
      load_pc_q <= load_pc;
      mem_wr_q  <= mem_wr;
      if (halt)
        halted_q <= 1'b1;
      if (ir_go)
        ir <= rdata;
      if (ac_go)
        ac <= alu_res;
      if (pc_go)
        pc <= operand;
      else if (inc_go)
        pc <= pc + AWIDTH'(1);
      if (wr_go)
        mem[operand] <= ac;
    end
  end

`ifdef RESP_SEQ_CHECK_EN
  logic illegal;
  logic seq_err_q;

  always_comb begin
    illegal = 1'b0;
    if (mem_rd  && phase[1:0] == 2'b00)                  illegal = 1'b1;
    if (load_ir && phase[2:1] != 2'b01)                  illegal = 1'b1;
    if (halt    && phase != 3'd4)                        illegal = 1'b1;
    if (inc_pc  && phase != 3'd4 && phase[2:1] != 2'b11) illegal = 1'b1;
    if (load_ac && phase[2:1] != 2'b11)                  illegal = 1'b1;
    if (load_pc && phase[2:1] != 2'b11)                  illegal = 1'b1;
    if (mem_wr  && phase != 3'd7)                        illegal = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      seq_err_q <= 1'b0;
    end else if (!halted_q && illegal && !seq_err_q) begin
      seq_err_q <= 1'b1;
      $error("ctrl_responder seq_err: phase %0d strobes %b", phase,
             {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr});
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_responder.sv
// tb/tb_ctrl_responder.sv - closed-loop bench: bench controller drives strobes, ISA-level model checks state
module tb_ctrl_responder;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       mem_rd = 0, load_ir = 0, halt = 0, inc_pc = 0, load_ac = 0, load_pc = 0, mem_wr = 0;
  logic       prog_we = 0;
  logic [4:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [2:0] opcode;
  logic       zero;
  logic [4:0] pc_out;
  logic [7:0] ac_out;
  logic       halted;
  logic       seq_err;

  always #5 clk = ~clk;

  ctrl_responder dut (
    .clk(clk), .rst_(rst_),
    .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
    .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
    .opcode(opcode), .zero(zero),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .pc_out(pc_out), .ac_out(ac_out), .halted(halted), .seq_err(seq_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Instruction-level architectural model.
  logic [7:0] m_mem [32];
  logic [4:0] m_pc;
  logic [7:0] m_ac;
  logic [7:0] m_ir;
  logic       m_halted;
  logic       exp_valid = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("pc", 32'(pc_out), 32'(m_pc));
      check("ac", 32'(ac_out), 32'(m_ac));
      check("opcode", 32'(opcode), 32'(m_ir[7:5]));
      check("zero", 32'(zero), 32'(m_ac == 8'h00));
      check("halted", 32'(halted), 32'(m_halted));
      check("seq_err", 32'(seq_err), 32'd0);
    end
  end

  task automatic model_reset();
    m_pc = '0; m_ac = '0; m_ir = '0; m_halted = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] ins;
    logic [7:0] d;
    if (m_halted) return;
    ins  = m_mem[m_pc];
    d    = m_mem[ins[4:0]];
    m_ir = ins;
    m_pc = m_pc + 5'd1;
    case (ins[7:5])
      3'd0: m_halted = 1'b1;
      3'd1: if (m_ac == 8'h00) m_pc = m_pc + 5'd1;
      3'd2: m_ac = m_ac + d;
      3'd3: m_ac = m_ac & d;
      3'd4: m_ac = m_ac ^ d;
      3'd5: m_ac = d;
      3'd6: m_mem[ins[4:0]] = m_ac;
      default: m_pc = ins[4:0];
    endcase
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_strobes();
    {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = '0;
  endtask

  // Controller behaviour for one phase, reacting to the DUT's opcode/zero.
  task automatic set_strobes(input int p);
    logic alu;
    alu = (opcode inside {3'd2, 3'd3, 3'd4, 3'd5});
    clr_strobes();
    case (p)
      1: mem_rd = 1'b1;
      2, 3: begin mem_rd = 1'b1; load_ir = 1'b1; end
      4: begin inc_pc = 1'b1; halt = (opcode == 3'd0); end
      5: mem_rd = alu;
      6: begin
        mem_rd = alu; load_ac = alu;
        inc_pc = (opcode == 3'd1) && zero;
        load_pc = (opcode == 3'd7);
      end
      7: begin
        mem_rd = alu; load_ac = alu;
        load_pc = (opcode == 3'd7);
        mem_wr = (opcode == 3'd6);
      end
      default: ;
    endcase
  endtask

  task automatic run_phases(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) begin
      set_strobes(p);
      tick();
      exp_valid = 1'b0;
    end
  endtask

  task automatic run_instr();
    run_phases(0, 7);
    clr_strobes();
    model_step();
    exp_valid = 1'b1;
  endtask

  task automatic run_halted(input int n);
    for (int i = 0; i < n; i++) begin
      {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = 7'($urandom);
      prog_we   = 1'($urandom);
      prog_addr = 5'($urandom);
      prog_data = 8'($urandom);
      tick();
    end
    clr_strobes();
    prog_we = 1'b0;
  endtask

  task automatic reset_begin();
    @(negedge clk); #1;
    clr_strobes();
    rst_ = 1'b0;
    exp_valid = 1'b0;
    tick();
    model_reset();
    exp_valid = 1'b1;
  endtask

  task automatic prog(input logic [4:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    m_mem[a] = d;
    prog_we = 1'b0;
  endtask

  task automatic reset_end();
    prog_we = 1'b0;
    rst_ = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    model_reset();
    tick();

    // LDA 5 with mem[5]=0
    reset_begin();
    for (int i = 0; i < 32; i++) prog(5'(i), 8'h00);
    prog(5'd0, 8'hA5);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_pc", 32'(pc_out), 32'd0);
    reset_end();
    run_instr();
    check("lda0_ac", 32'(ac_out), 32'h00);
    check("lda0_zero", 32'(zero), 32'd1);
    check("lda0_pc", 32'(pc_out), 32'd1);
    check("lda0_opcode", 32'(opcode), 32'd5);

    // LDA 10, ADD 11, STO 12, HLT
    reset_begin();
    prog(5'd0, 8'hAA); prog(5'd1, 8'h4B); prog(5'd2, 8'hCC); prog(5'd3, 8'h00);
    prog(5'd10, 8'hF0); prog(5'd11, 8'h20); prog(5'd12, 8'h55);
    reset_end();
    for (int i = 0; i < 4; i++) run_instr();
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_pc", 32'(pc_out), 32'd4);
    run_halted(20);
    check("hlt_ac_hold", 32'(ac_out), 32'h10);
    reset_begin();
    prog(5'd0, 8'hAC);
    reset_end();
    run_instr();
    check("sto_mem12", 32'(ac_out), 32'h10);

    // SKZ at pc=2, ac zero then nonzero
    for (int k = 0; k < 2; k++) begin
      reset_begin();
      prog(5'd0, 8'hB4); prog(5'd1, 8'hB4); prog(5'd2, 8'h20); prog(5'd20, 8'(k));
      reset_end();
      for (int i = 0; i < 3; i++) run_instr();
      check("skz_pc", 32'(pc_out), (k == 0) ? 32'd4 : 32'd3);
    end

    // JMP 31 at pc 31, then fall-through wrap 31 -> 0
    reset_begin();
    prog(5'd0, 8'hFF); prog(5'd31, 8'hFF);
    reset_end();
    run_instr(); run_instr();
    check("jmp31_pc", 32'(pc_out), 32'd31);
    reset_begin();
    prog(5'd31, 8'hA0);
    reset_end();
    run_instr(); run_instr();
    check("wrap_pc", 32'(pc_out), 32'd0);
    check("wrap_ac", 32'(ac_out), 32'hFF);

    // Reset during ALU_OP of ADD
    reset_begin();
    prog(5'd0, 8'hAA); prog(5'd1, 8'h4B);
    reset_end();
    run_instr();
    run_phases(0, 5);
    set_strobes(6);
    rst_ = 1'b0;
    tick();
    clr_strobes();
    check("abort_ac", 32'(ac_out), 32'd0);
    check("abort_pc", 32'(pc_out), 32'd0);
    check("abort_opcode", 32'(opcode), 32'd0);
    model_reset();
    rst_ = 1'b1;
    exp_valid = 1'b1;
    run_instr();
    check("abort_refetch_ac", 32'(ac_out), 32'hF0);
    check("abort_refetch_pc", 32'(pc_out), 32'd1);

    // Random programs
    for (int t = 0; t < 6; t++) begin
      reset_begin();
      for (int a = 0; a < 32; a++) begin
        r = 8'($urandom);
        if (r[7:5] == 3'd0 && $urandom_range(3) != 0) r[7:5] = 3'd5;
        prog(5'(a), r);
      end
      reset_end();
      for (int i = 0; i < 40 && !m_halted; i++) run_instr();
      if (m_halted) run_halted(12);
    end

    // Protocol violation: load_ir high in OP_FETCH
    reset_begin();
    prog(5'd0, 8'hA5);
    reset_end();
    run_phases(0, 4);
    clr_strobes();
    load_ir = 1'b1;
    tick();
    clr_strobes();
`ifdef RESP_SEQ_CHECK_EN
    check("seq_err_set", 32'(seq_err), 32'd1);
    run_phases(6, 7);
    check("seq_err_sticky", 32'(seq_err), 32'd1);
    reset_begin();
    check("seq_err_cleared", 32'(seq_err), 32'd0);
    exp_valid = 1'b0;
`else
    check("seq_err_tied", 32'(seq_err), 32'd0);
    run_phases(6, 7);
    check("seq_err_tied_later", 32'(seq_err), 32'd0);
`endif
    exp_valid = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
